// File: rtl/fx_bus_pkg.sv
// Shared fx register-bus definitions: bus widths, burst opcodes and the
// bus-master state encoding.
package fx_bus_pkg;

  localparam int FX_AW      = 22;
  localparam int FX_DW      = 8;
  localparam int FX_DEV_MSB = 21;
  localparam int FX_DEV_LSB = 16;
  localparam int FX_DEV_W   = FX_DEV_MSB - FX_DEV_LSB + 1;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADR2  = 4'd1;
  localparam logic [3:0] S_ADR1  = 4'd2;
  localparam logic [3:0] S_ADR0  = 4'd3;
  localparam logic [3:0] S_LEN   = 4'd4;
  localparam logic [3:0] S_WDAT  = 4'd5;
  localparam logic [3:0] S_RISS  = 4'd6;
  localparam logic [3:0] S_RWAIT = 4'd7;
  localparam logic [3:0] S_RSND  = 4'd8;

  // A length byte of zero encodes a full 256-byte burst.
  function automatic logic [8:0] lenToCount(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/fx_bus_master.sv
// fx register-bus initiator: turns host-link command bytes into burst register
// writes/reads and returns read data as a byte stream.
module fx_bus_master
  import fx_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  OP_WR  = fx_bus_pkg::OP_WR,
  parameter logic [7:0]  OP_RD  = fx_bus_pkg::OP_RD
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic [7:0]           rsp_data,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [FX_AW-1:0]     fx_waddr,
  output logic                 fx_wr,
  output logic [FX_DW-1:0]     fx_data,
  output logic [FX_AW-1:0]     fx_raddr,
  output logic                 fx_rd,
  input  logic [FX_DW-1:0]     fx_q,
  output logic                 busy,
  output logic                 err_op
);

  // Legal RD_LAT range is 1..3, so two bits hold the latency count.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  logic [3:0]          state_q, state_d;
  logic [FX_DEV_W-1:0] dev_q, dev_d;
  logic [15:0]         off_q, off_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                isRd_q, isRd_d;
  logic [1:0]          lat_q, lat_d;
  logic                fxWr_q, fxWr_d;
  logic                fxRd_q, fxRd_d;
  logic [FX_DW-1:0]    fxData_q, fxData_d;
  logic [FX_AW-1:0]    fxWaddr_q, fxWaddr_d;
  logic [FX_AW-1:0]    fxRaddr_q, fxRaddr_d;
  logic [7:0]          rspData_q, rspData_d;
  logic                rspVld_q, rspVld_d;
  logic                errOp_q, errOp_d;
  logic                cmdAccept;
  logic [15:0]         offNext;

  assign cmd_rdy   = (state_q == S_IDLE) || (state_q == S_ADR2) || (state_q == S_ADR1) ||
                     (state_q == S_ADR0) || (state_q == S_LEN)  || (state_q == S_WDAT);
  assign cmdAccept = cmd_vld && cmd_rdy;
  assign offNext   = off_q + 16'd1;

  // fx_rd is raised on the edge that enters RISS, so the strobe is high for
  // the whole RISS cycle and RWAIT only has to cover the RD_LAT return cycles.
  always_comb begin
    state_d   = state_q;
    dev_d     = dev_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    isRd_d    = isRd_q;
    lat_d     = lat_q;
    fxWr_d    = 1'b0;
    fxRd_d    = 1'b0;
    fxData_d  = fxData_q;
    fxWaddr_d = fxWaddr_q;
    fxRaddr_d = fxRaddr_q;
    rspData_d = rspData_q;
    rspVld_d  = rspVld_q;
    errOp_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmdAccept) begin
          if ((cmd_data == OP_WR) || (cmd_data == OP_RD)) begin
            isRd_d  = (cmd_data == OP_RD);
            state_d = S_ADR2;
          end else begin
            errOp_d = 1'b1;
          end
        end
      end
      S_ADR2: begin
        if (cmdAccept) begin
          dev_d   = cmd_data[FX_DEV_W-1:0];
          state_d = S_ADR1;
        end
      end
      S_ADR1: begin
        if (cmdAccept) begin
          off_d[15:8] = cmd_data;
          state_d     = S_ADR0;
        end
      end
      S_ADR0: begin
        if (cmdAccept) begin
          off_d[7:0] = cmd_data;
          state_d    = S_LEN;
        end
      end
      S_LEN: begin
        if (cmdAccept) begin
          cnt_d = lenToCount(cmd_data);
          if (isRd_q) begin
            fxRd_d    = 1'b1;
            fxRaddr_d = {dev_q, off_q};
            state_d   = S_RISS;
          end else begin
            state_d = S_WDAT;
          end
        end
      end
      S_WDAT: begin
        if (cmdAccept) begin
          fxWr_d    = 1'b1;
          fxData_d  = cmd_data;
          fxWaddr_d = {dev_q, off_q};
          off_d     = offNext;
          cnt_d     = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RISS: begin
        lat_d   = 2'd1;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_q == LAT_LAST) begin
          rspData_d = fx_q;
          rspVld_d  = 1'b1;
          state_d   = S_RSND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RSND: begin
        if (rsp_rdy) begin
          rspVld_d = 1'b0;
          off_d    = offNext;
          cnt_d    = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            fxRd_d    = 1'b1;
            fxRaddr_d = {dev_q, offNext};
            state_d   = S_RISS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Asynchronous reset drops strobes at once and abandons any partial packet.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dev_q     <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      isRd_q    <= 1'b0;
      lat_q     <= '0;
      fxWr_q    <= 1'b0;
      fxRd_q    <= 1'b0;
      fxData_q  <= '0;
      fxWaddr_q <= '0;
      fxRaddr_q <= '0;
      rspData_q <= '0;
      rspVld_q  <= 1'b0;
      errOp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      isRd_q    <= isRd_d;
      lat_q     <= lat_d;
      fxWr_q    <= fxWr_d;
      fxRd_q    <= fxRd_d;
      fxData_q  <= fxData_d;
      fxWaddr_q <= fxWaddr_d;
      fxRaddr_q <= fxRaddr_d;
      rspData_q <= rspData_d;
      rspVld_q  <= rspVld_d;
      errOp_q   <= errOp_d;
    end
  end

  assign fx_wr    = fxWr_q;
  assign fx_rd    = fxRd_q;
  assign fx_data  = fxData_q;
  assign fx_waddr = fxWaddr_q;
  assign fx_raddr = fxRaddr_q;
  assign rsp_data = rspData_q;
  assign rsp_vld  = rspVld_q;
  assign err_op   = errOp_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fx_bus_master.sv
// Bench for fx_bus_master: two instances (RD_LAT 1 and 3) share one command
// stream, each backed by a dev_id 5 register slave with matching read latency.
module tb_fx_bus_master;

  localparam int NVEC = 9;
  localparam int LOGN = 1024;

  typedef struct {
    logic [63:0] pkt;
    int          nBytes;
    int          expWr;
    int          expRd;
    int          expErr;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [7:0]  cmdData;
  logic        cmdVld;
  logic        rspRdy;
  logic [1:0]  cmdRdy;
  logic [1:0]  rspVld;
  logic [1:0]  fxWr;
  logic [1:0]  fxRd;
  logic [1:0]  busy;
  logic [1:0]  errOp;
  logic [7:0]  rspData [2];
  logic [21:0] fxWaddr [2];
  logic [7:0]  fxData  [2];
  logic [21:0] fxRaddr [2];
  logic [7:0]  fxQ     [2];

  always #5 clk_sys = ~clk_sys;

  fx_bus_master #(.RD_LAT(1)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .cmd_data(cmdData), .cmd_vld(cmdVld),
    .cmd_rdy(cmdRdy[0]), .rsp_data(rspData[0]), .rsp_vld(rspVld[0]), .rsp_rdy(rspRdy),
    .fx_waddr(fxWaddr[0]), .fx_wr(fxWr[0]), .fx_data(fxData[0]), .fx_raddr(fxRaddr[0]),
    .fx_rd(fxRd[0]), .fx_q(fxQ[0]), .busy(busy[0]), .err_op(errOp[0])
  );

  fx_bus_master #(.RD_LAT(3)) dut3 (
    .clk_sys(clk_sys), .rst_n(rst_n), .cmd_data(cmdData), .cmd_vld(cmdVld),
    .cmd_rdy(cmdRdy[1]), .rsp_data(rspData[1]), .rsp_vld(rspVld[1]), .rsp_rdy(rspRdy),
    .fx_waddr(fxWaddr[1]), .fx_wr(fxWr[1]), .fx_data(fxData[1]), .fx_raddr(fxRaddr[1]),
    .fx_rd(fxRd[1]), .fx_q(fxQ[1]), .busy(busy[1]), .err_op(errOp[1])
  );

  // Slave model for dev_id 5: q is driven only RD_LAT cycles after fx_rd, 0 otherwise.
  bit         memInit = 1'b0;
  logic [7:0] slaveMem [2][256];
  logic [7:0] qPipe    [2][3];

  always @(posedge clk_sys) begin
    if (!memInit) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 256; a++)
          slaveMem[i][a] <= 8'(a);
      memInit <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (fxWr[i] && fxWaddr[i][21:16] == 6'd5)
          slaveMem[i][fxWaddr[i][7:0]] <= fxData[i];
    end
    for (int i = 0; i < 2; i++) begin
      qPipe[i][0] <= (fxRd[i] && fxRaddr[i][21:16] == 6'd5) ? slaveMem[i][fxRaddr[i][7:0]] : 8'h00;
      qPipe[i][1] <= qPipe[i][0];
      qPipe[i][2] <= qPipe[i][1];
    end
  end

  assign fxQ[0] = qPipe[0][0];
  assign fxQ[1] = qPipe[1][2];

  // Bus monitor: logs strobes and handshakes, counts protocol violations.
  logic [21:0] wrAddrLog [2][LOGN];
  logic [7:0]  wrDataLog [2][LOGN];
  logic [21:0] rdAddrLog [2][LOGN];
  logic [7:0]  rspLog    [2][LOGN];
  int          wrCnt  [2] = '{0, 0};
  int          rdCnt  [2] = '{0, 0};
  int          rspCnt [2] = '{0, 0};
  int          errCnt [2] = '{0, 0};
  int          dualStrobe = 0;
  int          rdWhileVld = 0;
  int          holdBreaks = 0;
  logic        prevHold [2] = '{1'b0, 1'b0};
  logic [7:0]  prevData [2];

  always @(negedge clk_sys) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (fxWr[i]) begin
        wrAddrLog[i][wrCnt[i] % LOGN] <= fxWaddr[i];
        wrDataLog[i][wrCnt[i] % LOGN] <= fxData[i];
        wrCnt[i] <= wrCnt[i] + 1;
      end
      if (fxRd[i]) begin
        rdAddrLog[i][rdCnt[i] % LOGN] <= fxRaddr[i];
        rdCnt[i] <= rdCnt[i] + 1;
        if (rspVld[i]) rdWhileVld <= rdWhileVld + 1;
      end
      if (fxWr[i] && fxRd[i]) dualStrobe <= dualStrobe + 1;
      if (rspVld[i] && rspRdy) begin
        rspLog[i][rspCnt[i] % LOGN] <= rspData[i];
        rspCnt[i] <= rspCnt[i] + 1;
      end
      if (errOp[i]) errCnt[i] <= errCnt[i] + 1;
      if (prevHold[i] && (!rspVld[i] || rspData[i] != prevData[i])) holdBreaks <= holdBreaks + 1;
      prevHold[i] <= rspVld[i] && !rspRdy;
      prevData[i] <= rspData[i];
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] refMem [256];
  vec_t       vecs [NVEC];

  function automatic logic [7:0] refRead(input logic [5:0] dev, input logic [15:0] off);
    return (dev == 6'd5) ? refMem[off[7:0]] : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drives one packet byte per accepted handshake, left-aligned in pkt.
  task automatic applyStimulus(input logic [63:0] pkt, input int n);
    for (int b = 0; b < n; b++) begin
      int w = 0;
      cmdData = pkt[63-8*b -: 8];
      cmdVld  = 1'b1;
      while (!(cmdRdy[0] && cmdRdy[1]) && w < 10000) begin
        @(negedge clk_sys);
        w++;
      end
      checkOutput("cmdAcceptTimeout", b, 32'(w < 10000), 32'd1);
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
    cmdVld = 1'b0;
  endtask

  task automatic waitIdle();
    int w = 0;
    while ((busy[0] || busy[1] || rspVld[0] || rspVld[1]) && w < 8000) begin
      @(negedge clk_sys);
      w++;
    end
    checkOutput("idleTimeout", 0, 32'(w < 8000), 32'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    int wb [2];
    int rb [2];
    int sb [2];
    int eb [2];

    for (int a = 0; a < 256; a++) refMem[a] = 8'(a);
    vecs[0] = '{64'h5705004002341200, 7, 2, 0, 0};
    vecs[1] = '{64'h5205004002000000, 5, 0, 2, 0};
    vecs[2] = '{64'h5205008008000000, 5, 0, 8, 0};
    vecs[3] = '{64'h57C5FFFF02112200, 7, 2, 0, 0};
    vecs[4] = '{64'h5706123401AB0000, 6, 1, 0, 0};
    vecs[5] = '{64'hAA00000000000000, 1, 0, 0, 1};
    vecs[6] = '{64'h57050010015A0000, 6, 1, 0, 0};
    vecs[7] = '{64'h5205FFFF00000000, 5, 0, 256, 0};
    vecs[8] = '{64'h5206123401000000, 5, 0, 1, 0};

    rst_n = 1'b0; cmdVld = 1'b0; cmdData = 8'h00; rspRdy = 1'b1;
    repeat (3) @(negedge clk_sys);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rstFxWr", i, 32'(fxWr[i]), 0);
      checkOutput("rstFxRd", i, 32'(fxRd[i]), 0);
      checkOutput("rstBusy", i, 32'(busy[i]), 0);
      checkOutput("rstRspVld", i, 32'(rspVld[i]), 0);
      checkOutput("rstErrOp", i, 32'(errOp[i]), 0);
      checkOutput("rstWaddr", i, 32'(fxWaddr[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk_sys);
    checkOutput("idleCmdRdy", 0, 32'(cmdRdy), 32'd3);

    for (int v = 0; v < NVEC; v++) begin
      logic [63:0] p;
      logic [5:0]  dev;
      logic [15:0] off;
      logic [15:0] o;
      p   = vecs[v].pkt;
      dev = p[53:48];
      off = p[47:32];
      for (int i = 0; i < 2; i++) begin
        wb[i] = wrCnt[i]; rb[i] = rdCnt[i]; sb[i] = rspCnt[i]; eb[i] = errCnt[i];
      end
      applyStimulus(p, vecs[v].nBytes);
      waitIdle();
      for (int i = 0; i < 2; i++) begin
        checkOutput("wrCount", v, 32'(wrCnt[i] - wb[i]), 32'(vecs[v].expWr));
        checkOutput("rdCount", v, 32'(rdCnt[i] - rb[i]), 32'(vecs[v].expRd));
        checkOutput("rspCount", v, 32'(rspCnt[i] - sb[i]), 32'(vecs[v].expRd));
        checkOutput("errPulse", v, 32'(errCnt[i] - eb[i]), 32'(vecs[v].expErr));
        for (int k = 0; k < vecs[v].expWr; k++) begin
          o = off + 16'(k);
          checkOutput("wrAddr", v, 32'(wrAddrLog[i][(wb[i] + k) % LOGN]), 32'({dev, o}));
          checkOutput("wrData", v, 32'(wrDataLog[i][(wb[i] + k) % LOGN]), 32'(p[63-8*(5+k) -: 8]));
        end
        for (int k = 0; k < vecs[v].expRd; k++) begin
          o = off + 16'(k);
          checkOutput("rdAddr", v, 32'(rdAddrLog[i][(rb[i] + k) % LOGN]), 32'({dev, o}));
          checkOutput("rspData", v, 32'(rspLog[i][(sb[i] + k) % LOGN]), 32'(refRead(dev, o)));
        end
      end
      for (int k = 0; k < vecs[v].expWr; k++) begin
        o = off + 16'(k);
        if (dev == 6'd5) refMem[o[7:0]] = p[63-8*(5+k) -: 8];
      end
    end
    checkOutput("ringReadback", 0, 32'({refMem[8'h41], refMem[8'h40]}), 32'h1234);
    checkOutput("slaveRing", 0, 32'({slaveMem[0][8'h41], slaveMem[0][8'h40]}), 32'h1234);

    // Backpressure: rsp_rdy held low 10 cycles per byte, data must hold.
    for (int i = 0; i < 2; i++) begin rb[i] = rdCnt[i]; sb[i] = rspCnt[i]; end
    rspRdy = 1'b0;
    applyStimulus(64'h5205008003000000, 5);
    for (int b = 0; b < 3; b++) begin
      int w = 0;
      logic badCtl;
      badCtl = 1'b0;
      while (!(rspVld[0] && rspVld[1]) && w < 200) begin
        @(negedge clk_sys);
        w++;
      end
      checkOutput("bpVldTimeout", b, 32'(w < 200), 32'd1);
      repeat (10) begin
        @(negedge clk_sys);
        if (cmdRdy != 2'b00 || fxRd != 2'b00) badCtl = 1'b1;
      end
      checkOutput("bpCmdRdyLowNoRd", b, 32'(badCtl), 0);
      checkOutput("bpHold0", b, 32'(rspData[0]), 32'(refRead(6'd5, 16'h0080 + 16'(b))));
      checkOutput("bpHold3", b, 32'(rspData[1]), 32'(refRead(6'd5, 16'h0080 + 16'(b))));
      rspRdy = 1'b1;
      @(negedge clk_sys);
      rspRdy = 1'b0;
    end
    rspRdy = 1'b1;
    waitIdle();
    for (int i = 0; i < 2; i++) begin
      checkOutput("bpRdCount", i, 32'(rdCnt[i] - rb[i]), 32'd3);
      checkOutput("bpRspCount", i, 32'(rspCnt[i] - sb[i]), 32'd3);
    end

    // Reset mid-burst: strobes and busy drop asynchronously.
    applyStimulus(64'h5705002004AA0000, 6);
    checkOutput("midBusy", 0, 32'(busy), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncWrDrop", 0, 32'(fxWr), 0);
    checkOutput("asyncBusyDrop", 0, 32'(busy), 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 2; i++) begin wb[i] = wrCnt[i]; sb[i] = rspCnt[i]; end
    applyStimulus(64'h5705003001770000, 6);
    waitIdle();
    refMem[8'h30] = 8'h77;
    applyStimulus(64'h5205003001000000, 5);
    waitIdle();
    for (int i = 0; i < 2; i++) begin
      checkOutput("postRstWrCount", i, 32'(wrCnt[i] - wb[i]), 32'd1);
      checkOutput("postRstWrAddr", i, 32'(wrAddrLog[i][wb[i] % LOGN]), 32'h050030);
      checkOutput("postRstWrData", i, 32'(wrDataLog[i][wb[i] % LOGN]), 32'h77);
      checkOutput("postRstRsp", i, 32'(rspLog[i][sb[i] % LOGN]), 32'(refRead(6'd5, 16'h0030)));
    end

    checkOutput("dualStrobe", 0, 32'(dualStrobe), 0);
    checkOutput("rdWhileRspVld", 0, 32'(rdWhileVld), 0);
    checkOutput("rspHoldBreaks", 0, 32'(holdBreaks), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
